// File: rtl/last_unique_pkg.sv
// Shared constants and width helpers for the last-unique-N tracker.
// Imported by the interface, the match sub-module and the top.
package last_unique_pkg;

  localparam int unsigned DEF_WIDTH = 32'd8;
  localparam int unsigned DEF_DEPTH = 32'd4;

  // Width of a counter that must reach depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 32'd1);
  endfunction

  // Width of a slot index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 32'd1) ? $clog2(depth) : 32'd1;
  endfunction

endpackage

// File: rtl/last_unique_n_if.sv
// Data/status bundle of the last-unique-N tracker.
// The bench drives through master; the tracker sits on slave.
interface last_unique_n_if
  import last_unique_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);

  localparam int CW = cnt_width(DEPTH);
  localparam int IW = idx_width(DEPTH);

  logic                   in_valid;
  logic [WIDTH-1:0]       data_in;
  logic                   flush;
  logic [DEPTH*WIDTH-1:0] data_out;
  logic [DEPTH-1:0]       slot_valid;
  logic [CW-1:0]          count;
  logic                   hit;
  logic [IW-1:0]          hit_idx;

  modport master (
    output in_valid, data_in, flush,
    input  data_out, slot_valid, count, hit, hit_idx
  );

  modport slave (
    input  in_valid, data_in, flush,
    output data_out, slot_valid, count, hit, hit_idx
  );

endinterface

// File: rtl/lu_match.sv
// Per-slot equality compare against the key plus lowest-index priority encoder.
// Slots whose valid bit is clear never produce a match.
module lu_match
  import last_unique_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int IW = idx_width(DEPTH)
) (
  input  logic [DEPTH*WIDTH-1:0] slots,
  input  logic [DEPTH-1:0]       slot_valid,
  input  logic [WIDTH-1:0]       key,
  output logic                   match,
  output logic [IW-1:0]          match_idx
);

  logic [DEPTH-1:0] eq_s;

  for (genvar k = 0; k < DEPTH; k++) begin : g_cmp
    assign eq_s[k] = slot_valid[k] && (slots[k*WIDTH +: WIDTH] == key);
  end

  // Walk from the top down so the lowest matching slot wins.
  always_comb begin
    match     = |eq_s;
    match_idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      match_idx = eq_s[k] ? IW'(k) : match_idx;
    end
  end

endmodule

// File: rtl/last_unique_n.sv
// Ordered list of the DEPTH most recently seen distinct values, newest in slot 0.
// A hit moves the value to the front; a miss pushes it in and drops the oldest.
module last_unique_n
  import last_unique_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic            clk,
  input logic            rst_n,
  last_unique_n_if.slave bus
);

  localparam int CW = cnt_width(DEPTH);
  localparam int IW = idx_width(DEPTH);

  logic [DEPTH*WIDTH-1:0] data_s;
  logic [DEPTH-1:0]       valid_r, valid_nxt_s;
  logic [CW-1:0]          count_r, count_nxt_s;
  logic                   hit_r, hit_nxt_s;
  logic [IW-1:0]          hit_idx_r, hit_idx_nxt_s;
  logic                   match_s;
  logic [IW-1:0]          match_idx_s;

  lu_match #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_match (
    .slots      (data_s),
    .slot_valid (valid_r),
    .key        (bus.data_in),
    .match      (match_s),
    .match_idx  (match_idx_s)
  );

  // Each slot either holds, clears, or takes its upper neighbour; slots above a hit stay put.
  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    logic [WIDTH-1:0] slot_r, slot_nxt_s, shift_in_s;

    if (k == 0) begin : g_head
      assign shift_in_s = bus.data_in;
    end else begin : g_body
      assign shift_in_s = data_s[(k-1)*WIDTH +: WIDTH];
    end

    // Next value of this slot.
    always_comb begin
      slot_nxt_s = slot_r;
      if (bus.flush) begin
        slot_nxt_s = '0;
      end else if (!bus.in_valid) begin
        slot_nxt_s = slot_r;
      end else if (match_s && (int'(match_idx_s) < k)) begin
        slot_nxt_s = slot_r;
      end else begin
        slot_nxt_s = shift_in_s;
      end
    end

    // Slot storage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_r <= '0;
      end else begin
        slot_r <= slot_nxt_s;
      end
    end

    assign data_s[k*WIDTH +: WIDTH] = slot_r;
  end

  // Occupancy and hit status; a hit never changes occupancy.
  always_comb begin
    valid_nxt_s   = valid_r;
    count_nxt_s   = count_r;
    hit_nxt_s     = hit_r;
    hit_idx_nxt_s = hit_idx_r;
    if (bus.flush) begin
      valid_nxt_s   = '0;
      count_nxt_s   = '0;
      hit_nxt_s     = 1'b0;
      hit_idx_nxt_s = '0;
    end else if (bus.in_valid) begin
      if (match_s) begin
        hit_nxt_s     = 1'b1;
        hit_idx_nxt_s = match_idx_s;
      end else begin
        valid_nxt_s   = {valid_r[DEPTH-2:0], 1'b1};
        count_nxt_s   = (count_r == CW'(DEPTH)) ? count_r : (count_r + CW'(1));
        hit_nxt_s     = 1'b0;
        hit_idx_nxt_s = '0;
      end
    end else begin
      hit_nxt_s = hit_r;
    end
  end

  // Status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r   <= '0;
      count_r   <= '0;
      hit_r     <= 1'b0;
      hit_idx_r <= '0;
    end else begin
      valid_r   <= valid_nxt_s;
      count_r   <= count_nxt_s;
      hit_r     <= hit_nxt_s;
      hit_idx_r <= hit_idx_nxt_s;
    end
  end

  assign bus.data_out   = data_s;
  assign bus.slot_valid = valid_r;
  assign bus.count      = count_r;
  assign bus.hit        = hit_r;
  assign bus.hit_idx    = hit_idx_r;

endmodule

// File: tb/tb_last_unique_n.sv
// Scoreboard bench for last_unique_n: a queue-based list model predicts each cycle,
// a monitor compares one cycle later. Covers the default and a WIDTH=4/DEPTH=8 instance.
module tb_last_unique_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  last_unique_n_if #(.WIDTH(8), .DEPTH(4)) bus_a ();
  last_unique_n_if #(.WIDTH(4), .DEPTH(8)) bus_b ();

  last_unique_n #(.WIDTH(8), .DEPTH(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  last_unique_n #(.WIDTH(4), .DEPTH(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  typedef struct {
    bit          sel;
    logic [31:0] dout;
    logic [7:0]  sv;
    int          cnt;
    bit          hit;
    int          idx;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: a plain queue of values, newest at the front.
  int mq[$];
  int mdep = 4;
  int mwid = 8;
  bit mhit = 1'b0;
  int midx = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    mq.delete();
    mhit = 1'b0;
    midx = 0;
  endfunction

  function automatic void model_apply(input bit v, input int d, input bit fl);
    int pos;
    pos = -1;
    if (fl) begin
      model_clear();
    end else if (v) begin
      foreach (mq[i]) if (mq[i] == d && pos < 0) pos = i;
      if (pos >= 0) begin
        mq.delete(pos);
        mhit = 1'b1;
        midx = pos;
      end else begin
        mhit = 1'b0;
        midx = 0;
      end
      mq.push_front(d);
      if (mq.size() > mdep) void'(mq.pop_back());
    end
  endfunction

  function automatic exp_t snapshot(input bit sel);
    exp_t e;
    e.sel  = sel;
    e.dout = 32'h0;
    foreach (mq[i]) e.dout = e.dout | (32'(mq[i]) << (i * mwid));
    e.sv   = 8'((1 << mq.size()) - 1);
    e.cnt  = mq.size();
    e.hit  = mhit;
    e.idx  = midx;
    return e;
  endfunction

  task automatic idle();
    bus_a.in_valid = 1'b0; bus_a.flush = 1'b0; bus_a.data_in = 8'h0;
    bus_b.in_valid = 1'b0; bus_b.flush = 1'b0; bus_b.data_in = 4'h0;
  endtask

  task automatic step(input bit sel, input bit v, input int d, input bit fl);
    int dm;
    @(negedge clk);
    dm = d & ((1 << mwid) - 1);
    if (sel) begin
      bus_b.in_valid = v; bus_b.data_in = 4'(d); bus_b.flush = fl;
    end else begin
      bus_a.in_valid = v; bus_a.data_in = 8'(d); bus_a.flush = fl;
    end
    model_apply(v, dm, fl);
    sb.push_back(snapshot(sel));
    @(posedge clk);
    #1;
    idle();
  endtask

  // Monitor: one expectation per driven cycle, compared just after the edge.
  exp_t        me;
  logic [31:0] ad;
  logic [7:0]  asv;
  int          ac, ai;
  bit          ah;
  string       pre;
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      me = sb.pop_front();
      if (me.sel) begin
        ad = bus_b.data_out; asv = 8'(bus_b.slot_valid); ac = int'(bus_b.count);
        ah = bus_b.hit; ai = int'(bus_b.hit_idx); pre = "b";
      end else begin
        ad = bus_a.data_out; asv = 8'(bus_a.slot_valid); ac = int'(bus_a.count);
        ah = bus_a.hit; ai = int'(bus_a.hit_idx); pre = "a";
      end
      check({pre, "_data_out"},   64'(ad),  64'(me.dout));
      check({pre, "_slot_valid"}, 64'(asv), 64'(me.sv));
      check({pre, "_count"},      64'(ac),  64'(me.cnt));
      check({pre, "_hit"},        64'(ah),  64'(me.hit));
      check({pre, "_hit_idx"},    64'(ai),  64'(me.idx));
    end
  end

  initial begin
    int seq_a[4];
    idle();
    #1;
    check("rst_a_data_out", 64'(bus_a.data_out), 64'h0);
    check("rst_a_count", 64'(bus_a.count), 64'h0);
    check("rst_b_slot_valid", 64'(bus_b.slot_valid), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Default instance: directed sequence.
    mdep = 4; mwid = 8; model_clear();
    seq_a = '{1, 9, 2, 3};
    foreach (seq_a[i]) step(1'b0, 1'b1, seq_a[i], 1'b0);
    @(negedge clk);
    check("a_fill_order", 64'(bus_a.data_out), 64'h01090203);
    check("a_fill_count", 64'(bus_a.count), 64'd4);
    step(1'b0, 1'b1, 4, 1'b0);
    step(1'b0, 1'b1, 3, 1'b0);
    @(negedge clk);
    check("a_move_order", 64'(bus_a.data_out), 64'h09020403);
    check("a_move_idx", 64'(bus_a.hit_idx), 64'd1);
    step(1'b0, 1'b1, 7, 1'b0);
    step(1'b0, 1'b1, 7, 1'b0);
    step(1'b0, 1'b1, 1, 1'b0);
    step(1'b0, 1'b1, 1, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);

    // Flush beats a simultaneous in_valid.
    step(1'b0, 1'b0, 0, 1'b1);
    step(1'b0, 1'b1, 6, 1'b0);
    step(1'b0, 1'b1, 8, 1'b0);
    step(1'b0, 1'b1, 5, 1'b1);
    step(1'b0, 1'b1, 5, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);

    // Asynchronous reset between edges with three entries held.
    step(1'b0, 1'b0, 0, 1'b1);
    step(1'b0, 1'b1, 1, 1'b0);
    step(1'b0, 1'b1, 2, 1'b0);
    step(1'b0, 1'b1, 3, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_data_out", 64'(bus_a.data_out), 64'h0);
    check("arst_slot_valid", 64'(bus_a.slot_valid), 64'h0);
    check("arst_count", 64'(bus_a.count), 64'h0);
    check("arst_hit", 64'(bus_a.hit), 64'h0);
    bus_a.in_valid = 1'b1; bus_a.data_in = 8'd7;
    @(posedge clk);
    #1;
    check("arst_ignore_valid", 64'(bus_a.count), 64'h0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    step(1'b0, 1'b1, 9, 1'b0);
    @(negedge clk);
    check("arst_first_count", 64'(bus_a.count), 64'd1);

    // Default instance: random traffic over a small alphabet.
    repeat (300) begin
      int r;
      r = $urandom_range(0, 99);
      step(1'b0, r < 75, $urandom_range(0, 5), r < 5);
    end

    // Wide instance: ten distinct values then a hit three deep.
    mdep = 8; mwid = 4; model_clear();
    for (int i = 1; i <= 10; i++) step(1'b1, 1'b1, i, 1'b0);
    step(1'b1, 1'b1, 8, 1'b0);
    @(negedge clk);
    check("b_deep_count", 64'(bus_b.count), 64'd8);
    check("b_deep_idx", 64'(bus_b.hit_idx), 64'd2);
    check("b_deep_order", 64'(bus_b.data_out), 64'h345679A8);
    repeat (300) begin
      int r;
      r = $urandom_range(0, 99);
      step(1'b1, r < 75, $urandom_range(0, 11), r < 4);
    end

    @(negedge clk);
    @(negedge clk);
    check("sb_drain", 64'(sb.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/last_unique_n.md
LAST_UNIQUE_N -- requirements
Module: last_unique_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of each data word (1..32).
REQ-002 SHALL have parameter DEPTH, default 4, number of tracked unique values (2..16).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  data_in is sampled this cycle.
REQ-006 SHALL have port data_in  input  WIDTH  candidate value.
REQ-007 SHALL have port flush  input  1  synchronous clear of the list.
REQ-008 SHALL have port data_out  output  DEPTH*WIDTH  slot k at bits [k*WIDTH +: WIDTH]; slot 0 is most recent.
REQ-009 SHALL have port slot_valid  output  DEPTH  bit k set when slot k holds a value.
REQ-010 SHALL have port count  output  $clog2(DEPTH+1)  number of valid slots.
REQ-011 SHALL have port hit  output  1  registered: last accepted data_in matched a valid slot.
REQ-012 SHALL have port hit_idx  output  $clog2(DEPTH)  registered slot index of that match; 0 when hit=0.

Function
REQ-013 SHALL keep an ordered list of at most DEPTH distinct values, most recently seen at slot 0.
REQ-014 SHALL compare data_in against all valid slots combinationally; invalid slots SHALL never match.
REQ-015 On in_valid with a match at slot k, SHALL move the value to slot 0 and shift slots 0..k-1 down by one; slots above k unchanged.
REQ-016 On in_valid with no match, SHALL write data_in to slot 0 and shift all slots down by one; slot DEPTH-1 content is discarded.
REQ-017 On a miss with count<DEPTH, count SHALL increment by 1 and slot_valid SHALL gain bit count; on a miss at count=DEPTH, count SHALL stay DEPTH.
REQ-018 On a hit, count and slot_valid SHALL be unchanged.
REQ-019 All outputs SHALL reflect an accepted data_in one cycle after the sampling edge (latency 1).
REQ-020 hit and hit_idx SHALL update only on in_valid cycles and hold otherwise.
REQ-021 With in_valid=0 and flush=0, all state SHALL hold.
REQ-022 flush=1 SHALL clear slot_valid, count, hit, hit_idx and all data slots to 0 on the next edge.
REQ-023 flush and in_valid in the same cycle: flush SHALL win and data_in SHALL be dropped.
REQ-024 Slot valid bits SHALL always be contiguous from slot 0 (thermometer form).

Reset
REQ-025 rst_n low SHALL immediately force data_out=0, slot_valid=0, count=0, hit=0, hit_idx=0, independent of clk.
REQ-026 Reset asserted mid-stream SHALL discard all history; the first accepted value after release SHALL be a miss into slot 0.
REQ-027 in_valid SHALL be ignored while rst_n is low.

Structure
REQ-028 A shared package last_unique_pkg SHALL hold default WIDTH/DEPTH constants and a function for count/index widths.
REQ-029 Match logic (per-slot compare plus lowest-index priority encoder) SHALL be a sub-module lu_match.
REQ-030 The slot shift network SHALL be generated per slot, with no DEPTH-specific hand-coding.

Verification
REQ-031 Defaults; in_valid=1 with 1,9,2,3 -> after 4th edge data_out slots 0..3 = 3,2,9,1, count=4, slot_valid=1111, hit=0.
REQ-032 Continue with 4 -> slots 4,3,2,9 (1 evicted); then 3 -> slots 3,4,2,9, hit=1, hit_idx=1.
REQ-033 Continue with 7,7,1,1 -> after 7: 7,3,4,2; second 7 hit idx0 with list unchanged; after 1: 1,7,3,4; second 1 hit idx0.
REQ-034 After 2 values, assert flush with in_valid=1, data_in=5 -> count=0, slot_valid=0, next value 5 lands in slot 0 with count=1.
REQ-035 Drop rst_n between clock edges with count=3 -> outputs zero before the next edge; after release value 9 gives count=1, hit=0.
REQ-036 WIDTH=4, DEPTH=8 instance, 10 distinct values then a repeat of the 3rd-most-recent -> count=8, hit_idx=2, order updated per REQ-015.
